ov7670_resp_gen: RTL and testbench

Formats OV7670 SCCB register transaction results as ASCII response lines and streams them byte by byte to the UART transmitter. It is the host-bound counterpart of the command parser: each completed read, and optionally each completed write, becomes a 7-byte frame. The frame mirrors the command format `[R/W] ADR[7:4] ADR[3:0] DATA[7:4] DATA[3:0] CR LF`. It sits between the SCCB master's completion strobes and the UART TX byte interface.

---
 rtl/ov7670_resp_gen_pkg.sv | 27 ++
 rtl/ov7670_resp_gen_hex2ascii.sv | 16 +
 rtl/ov7670_resp_gen.sv | 157 +++++++++++++++
 tb/tb_ov7670_resp_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_resp_gen_pkg.sv
// Shared constants and types for the OV7670 SCCB response generator.
// Holds the ASCII framing characters (also used by the command parser),
// the response frame length, the FSM state type and the captured
// request payload.
package ov7670_resp_gen_pkg;

    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_W  = 8'h57;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int unsigned FRAME_LEN = 7;
    localparam int unsigned IDX_W     = 3;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_SENDING = 1'b1
    } state_t;

    // One captured SCCB completion: type, register address, data byte.
    typedef struct packed {
        logic       is_wr;
        logic [7:0] adr;
        logic [7:0] data;
    } resp_t;

endpackage

// File: rtl/ov7670_resp_gen_hex2ascii.sv
// hex2ascii: combinational nibble to uppercase ASCII hex digit encoder.
// Ports:
//   i_nib      in  4  nibble value 0-15
//   o_ascii_c  out 8  ASCII '0'-'9' / 'A'-'F' (combinational)
module hex2ascii (
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii_c
);

    logic [7:0] w_nib8;

    assign w_nib8    = {4'h0, i_nib};
    // 'A' - 10 = 8'h37, so both ranges are a single add on the nibble.
    assign o_ascii_c = (i_nib < 4'd10) ? 8'(8'h30 + w_nib8) : 8'(8'h37 + w_nib8);

endmodule

// File: rtl/ov7670_resp_gen.sv
// ov7670_resp_gen: turns SCCB read (and optionally write) completions into
// 7-byte ASCII frames "[R/W] A A D D CR LF" streamed to the UART TX.
// One active frame plus a one-deep pending slot; further requests are
// dropped and flagged on o_ovf.
// Ports:
//   CLK, RESETB      clock, async active-low reset
//   i_req_rd/i_req_wr one-cycle completion strobes (rd wins if both)
//   i_req_adr/data   register address / data, valid with the strobe
//   i_tx_ready       UART TX accepts the byte this cycle
//   o_tx_data/_en    registered byte offer to UART TX
//   o_busy           frame in progress or pending
//   o_ovf            one-cycle pulse: request dropped
module ov7670_resp_gen
    import ov7670_resp_gen_pkg::*;
#(
    parameter logic P_ECHO_WR = 1'b1
) (
    input  logic       CLK,
    input  logic       RESETB,
    input  logic       i_req_rd,
    input  logic       i_req_wr,
    input  logic [7:0] i_req_adr,
    input  logic [7:0] i_req_data,
    input  logic       i_tx_ready,
    output logic [7:0] o_tx_data,
    output logic       o_tx_data_en,
    output logic       o_busy,
    output logic       o_ovf
);

    state_t           r_state, w_nxt_state;
    resp_t            r_frame, w_nxt_frame;
    resp_t            r_pend, w_nxt_pend;
    resp_t            w_req_pkt;
    logic             r_pend_v, w_nxt_pend_v;
    logic [IDX_W-1:0] r_idx, w_nxt_idx;
    logic             w_req, w_acc, w_last, w_nxt_ovf;
    logic [3:0]       w_nib;
    logic [7:0]       w_hex, w_nxt_byte;
    logic [7:0]       r_tx_data;
    logic             r_tx_en, r_busy, r_ovf;

    // Request qualification and capture payload.
    assign w_req           = i_req_rd | (i_req_wr & P_ECHO_WR);
    assign w_req_pkt.is_wr = ~i_req_rd;
    assign w_req_pkt.adr   = i_req_adr;
    assign w_req_pkt.data  = i_req_data;

    assign w_acc  = (r_state == ST_SENDING) & i_tx_ready;
    assign w_last = (r_idx == IDX_W'(FRAME_LEN - 1));

    // State register and datapath registers.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state   <= ST_IDLE;
            r_frame   <= '0;
            r_pend    <= '0;
            r_pend_v  <= 1'b0;
            r_idx     <= '0;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_frame   <= w_nxt_frame;
            r_pend    <= w_nxt_pend;
            r_pend_v  <= w_nxt_pend_v;
            r_idx     <= w_nxt_idx;
            r_tx_data <= (w_nxt_state == ST_SENDING) ? w_nxt_byte : 8'h00;
            r_tx_en   <= (w_nxt_state == ST_SENDING);
            r_busy    <= (w_nxt_state != ST_IDLE) | w_nxt_pend_v;
            r_ovf     <= w_nxt_ovf;
        end
    end

    // Next-state, buffering and overflow decision.
    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_frame  = r_frame;
        w_nxt_pend   = r_pend;
        w_nxt_pend_v = r_pend_v;
        w_nxt_idx    = r_idx;
        w_nxt_ovf    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_nxt_frame = w_req_pkt;
                    w_nxt_idx   = '0;
                    w_nxt_state = ST_SENDING;
                end
            end
            ST_SENDING: begin
                if (w_acc && w_last) begin
                    // LF accepted: the pending slot drains first and may be
                    // refilled by a request arriving in this same cycle.
                    if (r_pend_v) begin
                        w_nxt_frame  = r_pend;
                        w_nxt_idx    = '0;
                        w_nxt_pend_v = w_req;
                        if (w_req) begin
                            w_nxt_pend = w_req_pkt;
                        end
                    end else if (w_req) begin
                        w_nxt_frame = w_req_pkt;
                        w_nxt_idx   = '0;
                    end else begin
                        w_nxt_state = ST_IDLE;
                    end
                end else begin
                    if (w_acc) begin
                        w_nxt_idx = r_idx + IDX_W'(1);
                    end
                    if (w_req) begin
                        if (!r_pend_v) begin
                            w_nxt_pend   = w_req_pkt;
                            w_nxt_pend_v = 1'b1;
                        end else begin
                            w_nxt_ovf = 1'b1;
                        end
                    end
                end
            end
            default: w_nxt_state = ST_IDLE;
        endcase
    end

    // Byte select for the next cycle's offer; one shared hex encoder.
    always_comb begin
        case (w_nxt_idx)
            IDX_W'(1): w_nib = w_nxt_frame.adr[7:4];
            IDX_W'(2): w_nib = w_nxt_frame.adr[3:0];
            IDX_W'(3): w_nib = w_nxt_frame.data[7:4];
            default:   w_nib = w_nxt_frame.data[3:0];
        endcase
        case (w_nxt_idx)
            IDX_W'(0): w_nxt_byte = w_nxt_frame.is_wr ? ASCII_W : ASCII_R;
            IDX_W'(1),
            IDX_W'(2),
            IDX_W'(3),
            IDX_W'(4): w_nxt_byte = w_hex;
            IDX_W'(5): w_nxt_byte = ASCII_CR;
            default:   w_nxt_byte = ASCII_LF;
        endcase
    end

    hex2ascii u_hex2ascii (
        .i_nib     (w_nib),
        .o_ascii_c (w_hex)
    );

    assign o_tx_data    = r_tx_data;
    assign o_tx_data_en = r_tx_en;
    assign o_busy       = r_busy;
    assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_ov7670_resp_gen.sv
// Testbench for ov7670_resp_gen. Reference model: a queue of the ASCII
// bytes still owed to the UART plus the rule "at most two frames held".
module tb_ov7670_resp_gen;

    logic       CLK = 1'b0;
    logic       RESETB = 1'b0;
    logic       i_req_rd = 1'b0, i_req_wr = 1'b0, i_tx_ready = 1'b0;
    logic [7:0] i_req_adr = 8'h00, i_req_data = 8'h00;
    logic [7:0] o_tx_data, n_tx_data;
    logic       o_tx_data_en, o_busy, o_ovf, n_en, n_busy, n_ovf;

    always #5 CLK = ~CLK;

    ov7670_resp_gen #(.P_ECHO_WR(1'b1)) dut (
        .CLK(CLK), .RESETB(RESETB), .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
        .i_req_adr(i_req_adr), .i_req_data(i_req_data), .i_tx_ready(i_tx_ready),
        .o_tx_data(o_tx_data), .o_tx_data_en(o_tx_data_en), .o_busy(o_busy), .o_ovf(o_ovf)
    );

    ov7670_resp_gen #(.P_ECHO_WR(1'b0)) dut_ne (
        .CLK(CLK), .RESETB(RESETB), .i_req_rd(i_req_rd), .i_req_wr(i_req_wr),
        .i_req_adr(i_req_adr), .i_req_data(i_req_data), .i_tx_ready(i_tx_ready),
        .o_tx_data(n_tx_data), .o_tx_data_en(n_en), .o_busy(n_busy), .o_ovf(n_ovf)
    );

    logic [7:0] q[$];
    logic       exp_en = 1'b0, exp_busy = 1'b0, exp_ovf = 1'b0;
    int         checks = 0, errors = 0;

    function automatic logic [7:0] hexc(input logic [3:0] n);
        if (n < 4'd10) return 8'("0") + 8'(n);
        return 8'("A") + 8'(n) - 8'd10;
    endfunction

    // Drive one cycle of inputs, advance the model across the clock edge,
    // and leave time at posedge+1 where outputs are sampled.
    task automatic step(input logic rd, input logic wr, input logic [7:0] adr,
                        input logic [7:0] data, input logic rdy);
        int   held;
        logic ovf_n;
        i_req_rd = rd; i_req_wr = wr; i_req_adr = adr; i_req_data = data;
        i_tx_ready = rdy;
        if (exp_en && rdy) void'(q.pop_front());
        held  = (q.size() + 6) / 7;
        ovf_n = 1'b0;
        if (rd || wr) begin
            if (held < 2) begin
                q.push_back(rd ? 8'("R") : 8'("W"));
                q.push_back(hexc(adr[7:4]));
                q.push_back(hexc(adr[3:0]));
                q.push_back(hexc(data[7:4]));
                q.push_back(hexc(data[3:0]));
                q.push_back(8'h0D);
                q.push_back(8'h0A);
            end else begin
                ovf_n = 1'b1;
            end
        end
        @(posedge CLK); #1;
        i_req_rd = 1'b0; i_req_wr = 1'b0;
        exp_en   = (q.size() != 0);
        exp_busy = exp_en;
        exp_ovf  = ovf_n;
    endtask

    task automatic test_reset;
        checks += 4;
        if (o_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", o_tx_data); end
        if (o_tx_data_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b exp 0", o_tx_data_en); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", o_busy); end
        if (o_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", o_ovf); end
    endtask

    task automatic test_read;
        logic [7:0] got[$];
        logic [7:0] ref_b[7] = '{8'h52, 8'h30, 8'h41, 8'h37, 8'h36, 8'h0D, 8'h0A};
        step(1'b1, 1'b0, 8'h0A, 8'h76, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checks += 3;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL read_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL read_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_ovf !== exp_ovf) begin errors++; $display("FAIL read_ovf cyc %0d got %b exp %b", k, o_ovf, exp_ovf); end
            if (exp_en) begin
                checks++;
                if (o_tx_data !== q[0]) begin errors++; $display("FAIL read_byte cyc %0d got %h exp %h", k, o_tx_data, q[0]); end
            end
            if (o_tx_data_en) got.push_back(o_tx_data);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        checks++;
        if (got.size() != 7) begin errors++; $display("FAIL read_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL read_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_write;
        logic [7:0] got[$];
        logic [7:0] ref_b[7] = '{8'h57, 8'h31, 8'h32, 8'h38, 8'h30, 8'h0D, 8'h0A};
        step(1'b0, 1'b1, 8'h12, 8'h80, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checks += 5;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL write_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL write_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_ovf !== exp_ovf) begin errors++; $display("FAIL write_ovf cyc %0d got %b exp %b", k, o_ovf, exp_ovf); end
            if (n_en !== 1'b0) begin errors++; $display("FAIL noecho_en cyc %0d got %b exp 0", k, n_en); end
            if (n_busy !== 1'b0) begin errors++; $display("FAIL noecho_busy cyc %0d got %b exp 0", k, n_busy); end
            if (o_tx_data_en) got.push_back(o_tx_data);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        checks++;
        if (got.size() != 7) begin errors++; $display("FAIL write_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL write_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_stall;
        logic [7:0] got[$];
        logic [7:0] ref_b[7] = '{8'h52, 8'h35, 8'h43, 8'h45, 8'h39, 8'h0D, 8'h0A};
        logic       rdy, prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0; prev_data = 8'h00;
        step(1'b1, 1'b0, 8'h5C, 8'hE9, 1'b1);
        for (int k = 0; k < 40 && exp_en; k++) begin
            rdy = (k % 4 == 0) || (k % 4 == 3);
            checks += 3;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL stall_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL stall_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_tx_data !== q[0]) begin errors++; $display("FAIL stall_byte cyc %0d got %h exp %h", k, o_tx_data, q[0]); end
            if (prev_hold) begin
                checks++;
                if (o_tx_data !== prev_data) begin errors++; $display("FAIL stall_hold cyc %0d got %h exp %h", k, o_tx_data, prev_data); end
            end
            prev_hold = o_tx_data_en && !rdy;
            prev_data = o_tx_data;
            if (o_tx_data_en && rdy) got.push_back(o_tx_data);
            step(1'b0, 1'b0, 8'h00, 8'h00, rdy);
        end
        checks += 2;
        if (exp_en !== 1'b0 || o_tx_data_en !== 1'b0) begin errors++; $display("FAIL stall_end got %b exp 0", o_tx_data_en); end
        if (got.size() != 7) begin errors++; $display("FAIL stall_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL stall_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got[$];
        logic [7:0] ref_b[14] = '{8'h52, 8'h30, 8'h31, 8'h46, 8'h46, 8'h0D, 8'h0A,
                                  8'h52, 8'h30, 8'h32, 8'h30, 8'h30, 8'h0D, 8'h0A};
        int ovf_cnt = 0;
        step(1'b1, 1'b0, 8'h01, 8'hFF, 1'b1);
        for (int j = 0; j < 18; j++) begin
            checks += 3;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL b2b_en cyc %0d got %b exp %b", j, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL b2b_busy cyc %0d got %b exp %b", j, o_busy, exp_busy); end
            if (o_ovf !== exp_ovf) begin errors++; $display("FAIL b2b_ovf cyc %0d got %b exp %b", j, o_ovf, exp_ovf); end
            if (exp_en) begin
                checks++;
                if (o_tx_data !== q[0]) begin errors++; $display("FAIL b2b_byte cyc %0d got %h exp %h", j, o_tx_data, q[0]); end
            end
            if (o_ovf) ovf_cnt++;
            if (o_tx_data_en) got.push_back(o_tx_data);
            step(j == 2 || j == 4, 1'b0, (j == 2) ? 8'h02 : 8'h03, (j == 2) ? 8'h00 : 8'h55, 1'b1);
        end
        checks += 2;
        if (ovf_cnt != 1) begin errors++; $display("FAIL b2b_ovf_count got %0d exp 1", ovf_cnt); end
        if (got.size() != 14) begin errors++; $display("FAIL b2b_len got %0d exp 14", got.size()); end
        for (int i = 0; i < 14 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL b2b_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_same_cycle;
        logic [7:0] got[$];
        logic [7:0] ref_b[7] = '{8'h52, 8'h33, 8'h41, 8'h30, 8'h34, 8'h0D, 8'h0A};
        step(1'b1, 1'b1, 8'h3A, 8'h04, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checks += 2;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL both_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL both_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_tx_data_en) got.push_back(o_tx_data);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        checks++;
        if (got.size() != 7) begin errors++; $display("FAIL both_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL both_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_reset_mid;
        logic [7:0] got[$];
        logic [7:0] ref_b[7] = '{8'h52, 8'h34, 8'h34, 8'h32, 8'h31, 8'h0D, 8'h0A};
        step(1'b1, 1'b0, 8'hA5, 8'h5A, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        i_tx_ready = 1'b0;
        #2 RESETB = 1'b0;
        #1;
        checks += 4;
        if (o_tx_data_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", o_tx_data_en); end
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", o_busy); end
        if (o_tx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h exp 00", o_tx_data); end
        if (o_ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %b exp 0", o_ovf); end
        q.delete();
        exp_en = 1'b0; exp_busy = 1'b0; exp_ovf = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESETB = 1'b1;
        @(posedge CLK); #1;
        step(1'b1, 1'b0, 8'h44, 8'h21, 1'b1);
        for (int k = 0; k < 9; k++) begin
            checks += 2;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL rstmid_post_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL rstmid_post_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_tx_data_en) got.push_back(o_tx_data);
            step(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
        end
        checks++;
        if (got.size() != 7) begin errors++; $display("FAIL rstmid_len got %0d exp 7", got.size()); end
        for (int i = 0; i < 7 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ref_b[i]) begin errors++; $display("FAIL rstmid_const[%0d] got %h exp %h", i, got[i], ref_b[i]); end
        end
    endtask

    task automatic test_random;
        logic rd, wr, rdy;
        for (int k = 0; k < 430; k++) begin
            rd  = (k < 400) && ($urandom_range(0, 7) == 0);
            wr  = (k < 400) && ($urandom_range(0, 7) == 0);
            rdy = (k >= 400) || ($urandom_range(0, 3) != 0);
            checks += 3;
            if (o_tx_data_en !== exp_en) begin errors++; $display("FAIL rand_en cyc %0d got %b exp %b", k, o_tx_data_en, exp_en); end
            if (o_busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", k, o_busy, exp_busy); end
            if (o_ovf !== exp_ovf) begin errors++; $display("FAIL rand_ovf cyc %0d got %b exp %b", k, o_ovf, exp_ovf); end
            if (exp_en) begin
                checks++;
                if (o_tx_data !== q[0]) begin errors++; $display("FAIL rand_byte cyc %0d got %h exp %h", k, o_tx_data, q[0]); end
            end
            step(rd, wr, 8'($urandom), 8'($urandom), rdy);
        end
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        test_reset;
        @(negedge CLK) RESETB = 1'b1;
        @(posedge CLK); #1;
        test_read;
        test_write;
        test_stall;
        test_back_to_back;
        test_same_cycle;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
